// File: rtl/food_placer_if.sv
// ---------------------------------------------------------------------------
// food_placer_if
//   Occupancy query handshake between the food placer and the snake-body store.
//   master (placer):    drives query_valid/query_x/query_y, receives query_done/occupied
//   slave  (responder): receives the query, answers with query_done/occupied
//   query_valid  placer has a query pending; query_x/query_y held stable meanwhile
//   query_x/y    cell coordinates being asked about
//   query_done   responder: occupied is valid this cycle (ends the query)
//   occupied     responder: the cell overlaps the snake body
// ---------------------------------------------------------------------------
interface food_placer_if #(
  parameter int unsigned COORD_W = 10
);
  logic               query_valid;
  logic [COORD_W-1:0] query_x;
  logic [COORD_W-1:0] query_y;
  logic               query_done;
  logic               occupied;

  modport master (
    output query_valid, query_x, query_y,
    input  query_done, occupied
  );

  modport slave (
    input  query_valid, query_x, query_y,
    output query_done, occupied
  );
endinterface

// File: rtl/food_placer.sv
// ---------------------------------------------------------------------------
// food_placer
//   On start or eaten, draws candidate coordinates from the free-running
//   rand_x/rand_y source, rejects candidates that are out of range or off the
//   grid, asks the snake-body store whether the cell is occupied, and retries
//   until a free cell is found or MAX_TRIES rejections pile up, at which point
//   the fixed fallback cell is published and place_fail pulses for one cycle.
//
// Ports
//   clk, rst          system clock, asynchronous active-high reset
//   start, eaten      single-cycle request pulses (ignored unless idle)
//   rand_x, rand_y    candidate coordinates from the generator
//   q                 occupancy query handshake (food_placer_if.master)
//   food_x, food_y    published food cell
//   food_valid        food_x/food_y are valid and drawable
//   place_fail        one-cycle pulse when the fallback cell was used
//   last_tries        (FOOD_PLACER_STATS_EN) rejections in the last placement
//   fail_count        (FOOD_PLACER_STATS_EN) saturating count of place_fail pulses
//
// Build option: define FOOD_PLACER_STATS_EN to add last_tries/fail_count.
// ---------------------------------------------------------------------------
module food_placer #(
  parameter int unsigned COORD_W    = 10,
  parameter int unsigned GRID       = 10,
  parameter int unsigned X_MIN      = 20,
  parameter int unsigned X_MAX      = 620,
  parameter int unsigned Y_MIN      = 20,
  parameter int unsigned Y_MAX      = 460,
  parameter int unsigned MAX_TRIES  = 15,
  parameter int unsigned FALLBACK_X = 320,
  parameter int unsigned FALLBACK_Y = 240
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               eaten,
  input  logic [COORD_W-1:0] rand_x,
  input  logic [COORD_W-1:0] rand_y,
  food_placer_if.master      q,
  output logic [COORD_W-1:0] food_x,
  output logic [COORD_W-1:0] food_y,
  output logic               food_valid,
  output logic               place_fail
`ifdef FOOD_PLACER_STATS_EN
  ,
  output logic [3:0]         last_tries,
  output logic [7:0]         fail_count
`endif
);

  localparam logic [COORD_W-1:0] XMIN_C = COORD_W'(X_MIN);
  localparam logic [COORD_W-1:0] XMAX_C = COORD_W'(X_MAX);
  localparam logic [COORD_W-1:0] YMIN_C = COORD_W'(Y_MIN);
  localparam logic [COORD_W-1:0] YMAX_C = COORD_W'(Y_MAX);
  localparam logic [COORD_W-1:0] GRID_C = COORD_W'(GRID);
  localparam logic [COORD_W-1:0] FB_X_C = COORD_W'(FALLBACK_X);
  localparam logic [COORD_W-1:0] FB_Y_C = COORD_W'(FALLBACK_Y);
  localparam logic [3:0]         TRIES_LIM = 4'(MAX_TRIES);

  typedef enum logic [1:0] {IDLE, SAMPLE, CHECK, QUERY} state_t;

  state_t             state, state_nxt;
  logic [COORD_W-1:0] cand_x, cand_y, cand_x_nxt, cand_y_nxt;
  logic [3:0]         tries, tries_nxt, tries_inc;
  logic               qv_nxt;
  logic [COORD_W-1:0] qx_nxt, qy_nxt;
  logic [COORD_W-1:0] food_x_nxt, food_y_nxt;
  logic               food_valid_nxt, place_fail_nxt;
  logic               request, cand_ok, reject, fallback;
`ifdef FOOD_PLACER_STATS_EN
  logic [3:0]         last_tries_nxt;
  logic [7:0]         fail_count_nxt;
`endif

  // Candidate qualification and rejection bookkeeping shared by both
  // combinational processes.
  always_comb begin
    request   = start | eaten;
    cand_ok   = (cand_x >= XMIN_C) && (cand_x <= XMAX_C) &&
                (cand_y >= YMIN_C) && (cand_y <= YMAX_C) &&
                ((cand_x % GRID_C) == '0) && ((cand_y % GRID_C) == '0);
    tries_inc = tries + 4'd1;
    reject    = ((state == CHECK) && !cand_ok) ||
                ((state == QUERY) && q.query_done && q.occupied);
    // tries tops out at MAX_TRIES (<= 15), so the 4-bit counter never wraps.
    fallback  = reject && (tries_inc == TRIES_LIM);
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (request) state_nxt = SAMPLE;
      SAMPLE: state_nxt = CHECK;
      CHECK:  if (cand_ok)       state_nxt = QUERY;
              else if (fallback) state_nxt = IDLE;
              else               state_nxt = SAMPLE;
      QUERY:  if (q.query_done) begin
                if (q.occupied && !fallback) state_nxt = SAMPLE;
                else                         state_nxt = IDLE;
              end
      default: state_nxt = IDLE;
    endcase
  end

  // Output/datapath next values; everything is registered below.
  always_comb begin
    cand_x_nxt     = cand_x;
    cand_y_nxt     = cand_y;
    tries_nxt      = tries;
    qv_nxt         = q.query_valid;
    qx_nxt         = q.query_x;
    qy_nxt         = q.query_y;
    food_x_nxt     = food_x;
    food_y_nxt     = food_y;
    food_valid_nxt = food_valid;
    place_fail_nxt = 1'b0;
`ifdef FOOD_PLACER_STATS_EN
    last_tries_nxt = last_tries;
    fail_count_nxt = fail_count;
`endif
    case (state)
      IDLE: if (request) begin
        food_valid_nxt = 1'b0;
        tries_nxt      = '0;
      end
      SAMPLE: begin
        cand_x_nxt = rand_x;
        cand_y_nxt = rand_y;
      end
      CHECK: if (cand_ok) begin
        qv_nxt = 1'b1;
        qx_nxt = cand_x;
        qy_nxt = cand_y;
      end
      QUERY: if (q.query_done) begin
        qv_nxt = 1'b0;
        if (!q.occupied) begin
          food_x_nxt     = cand_x;
          food_y_nxt     = cand_y;
          food_valid_nxt = 1'b1;
`ifdef FOOD_PLACER_STATS_EN
          last_tries_nxt = tries;
`endif
        end
      end
      default: ;
    endcase
    if (reject) begin
      tries_nxt = tries_inc;
      if (fallback) begin
        food_x_nxt     = FB_X_C;
        food_y_nxt     = FB_Y_C;
        food_valid_nxt = 1'b1;
        place_fail_nxt = 1'b1;
`ifdef FOOD_PLACER_STATS_EN
        last_tries_nxt = tries_inc;
        if (fail_count != '1) fail_count_nxt = fail_count + 8'd1;
`endif
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cand_x        <= '0;
      cand_y        <= '0;
      tries         <= '0;
      q.query_valid <= 1'b0;
      q.query_x     <= '0;
      q.query_y     <= '0;
      food_x        <= FB_X_C;
      food_y        <= FB_Y_C;
      food_valid    <= 1'b0;
      place_fail    <= 1'b0;
`ifdef FOOD_PLACER_STATS_EN
      last_tries    <= '0;
      fail_count    <= '0;
`endif
    end else begin
      state         <= state_nxt;
      cand_x        <= cand_x_nxt;
      cand_y        <= cand_y_nxt;
      tries         <= tries_nxt;
      q.query_valid <= qv_nxt;
      q.query_x     <= qx_nxt;
      q.query_y     <= qy_nxt;
      food_x        <= food_x_nxt;
      food_y        <= food_y_nxt;
      food_valid    <= food_valid_nxt;
      place_fail    <= place_fail_nxt;
`ifdef FOOD_PLACER_STATS_EN
      last_tries    <= last_tries_nxt;
      fail_count    <= fail_count_nxt;
`endif
    end
  end

endmodule
